// File: rtl/aes_pkg.sv
// Shared AES definitions: state width, FSM encoding and the byte-position helper
// used by the round datapath blocks.
package aes_pkg;

  localparam int STATE_W = 128;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } ssr_state_e;

  // MSB bit index of byte (row, col) in a column-major 128-bit state.
  function automatic int byte_ofs(input int row, input int col);
    return STATE_W - 1 - 8 * (4 * col + row);
  endfunction

endpackage

// File: rtl/sub_shift_rows_if.sv
// Valid/ready handshake bundle for the SubBytes+ShiftRows stage: input state
// towards the block, substituted state back out.
interface sub_shift_rows_if;
  import aes_pkg::*;

  logic               i_Valid;
  logic               o_Ready;
  logic [STATE_W-1:0] i_State;
  logic               i_fDec;
  logic               o_Valid;
  logic               i_Ready;
  logic [STATE_W-1:0] o_State;

  modport slave (
    input  i_Valid, i_State, i_fDec, i_Ready,
    output o_Ready, o_Valid, o_State
  );

  modport master (
    output i_Valid, i_State, i_fDec, i_Ready,
    input  o_Ready, o_Valid, o_State
  );

endinterface

// File: rtl/aes_sbox.sv
// Combinational AES S-box, forward or inverse, computed as GF(2^8) inversion
// wrapped by the affine transform instead of a lookup table.
module aes_sbox (
  input  logic       i_fDec,
  input  logic [7:0] i_Byte,
  output logic [7:0] o_Byte
);

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 == x^-1 in GF(2^8); zero maps to zero as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x2, x3, x12, x15, x240;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
    x15  = gf_mul(x12, x3);
    x240 = gf_mul(x15, x15);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    return gf_mul(gf_mul(x240, x12), x2);
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] b);
    return rotl(b, 1) ^ rotl(b, 3) ^ rotl(b, 6) ^ 8'h05;
  endfunction

  logic [7:0] w_pre;
  logic [7:0] w_inv;

  assign w_pre  = i_fDec ? inv_affine(i_Byte) : i_Byte;
  assign w_inv  = gf_inv(w_pre);
  assign o_Byte = i_fDec ? w_inv : affine(w_inv);

endmodule

// File: rtl/sub_shift_rows.sv
// Iterative AES SubBytes+ShiftRows (or inverse): one column per cycle through
// four shared S-boxes, each byte written straight to its row-shifted slot.
module sub_shift_rows
  import aes_pkg::*;
(
  input  logic              i_Clk,
  input  logic              i_Rst_n,
  sub_shift_rows_if.slave   bus
);

  ssr_state_e         r_state;
  logic [1:0]         r_cnt;
  logic               r_dec;
  logic               r_valid;
  logic [STATE_W-1:0] r_in;
  logic [STATE_W-1:0] r_out;

  logic [7:0]         w_col  [4];
  logic [7:0]         w_sub  [4];
  logic [1:0]         w_dcol [4];

  always_comb begin
    for (int r = 0; r < 4; r++) begin
      w_col[r]  = r_in[byte_ofs(r, int'(r_cnt)) -: 8];
      // Encrypt moves row r left by r columns, decrypt moves it right.
      w_dcol[r] = r_dec ? (r_cnt + 2'(r)) : (r_cnt - 2'(r));
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .i_fDec (r_dec),
      .i_Byte (w_col[g]),
      .o_Byte (w_sub[g])
    );
  end

  assign bus.o_Ready = (r_state == ST_IDLE) | ((r_state == ST_DONE) & bus.i_Ready);
  assign bus.o_Valid = r_valid;
  assign bus.o_State = r_out;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 2'd0;
      r_dec   <= 1'b0;
      r_valid <= 1'b0;
      r_in    <= '0;
      r_out   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.i_Valid) begin
            r_in    <= bus.i_State;
            r_dec   <= bus.i_fDec;
            r_cnt   <= 2'd0;
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          for (int r = 0; r < 4; r++) begin
            r_out[byte_ofs(r, int'(w_dcol[r])) -: 8] <= w_sub[r];
          end
          r_cnt <= r_cnt + 2'd1;
          if (r_cnt == 2'd3) begin
            r_state <= ST_DONE;
            r_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          if (bus.i_Ready) begin
            r_valid <= 1'b0;
            if (bus.i_Valid) begin
              r_in    <= bus.i_State;
              r_dec   <= bus.i_fDec;
              r_cnt   <= 2'd0;
              r_state <= ST_BUSY;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sub_shift_rows.sv
// Bench for sub_shift_rows: FIPS-197 vectors, constant states, backpressure,
// mid-block reset and randomized blocks against a table-driven reference.
module tb_sub_shift_rows;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  logic [7:0] sb  [256];
  logic [7:0] isb [256];

  sub_shift_rows_if bus ();

  sub_shift_rows dut (
    .i_Clk   (clk),
    .i_Rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // Classic generator walk: p steps by 3, q by 1/3, so q = p^-1 at every step.
  task automatic build_tables();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rl8(q, 1) ^ rl8(q, 2) ^ rl8(q, 3) ^ rl8(q, 4);
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
    for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);
  endtask

  function automatic logic [127:0] ref_ssr(input logic [127:0] s, input logic d);
    logic [127:0] res;
    logic [7:0]   v;
    int           src;
    res = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        src = d ? (c - r + 4) % 4 : (c + r) % 4;
        v   = s[127 - 8 * (4 * src + r) -: 8];
        res[127 - 8 * (4 * c + r) -: 8] = d ? isb[v] : sb[v];
      end
    end
    return res;
  endfunction

  // Called at a negedge with o_Ready high; returns at the negedge after acceptance.
  task automatic send(input logic [127:0] s, input logic d);
    bus.i_Valid = 1'b1;
    bus.i_State = s;
    bus.i_fDec  = d;
    @(posedge clk);
    @(negedge clk);
    bus.i_Valid = 1'b0;
    bus.i_State = {$urandom, $urandom, $urandom, $urandom};
    bus.i_fDec  = 1'($urandom);
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!bus.o_Valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic consume();
    bus.i_Ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.i_Ready = 1'b0;
  endtask

  task automatic run_block(input string tag, input logic [127:0] s, input logic d,
                           input logic [127:0] exp);
    int lat;
    send(s, d);
    wait_out(lat);
    chk({tag, "_lat"}, 128'(lat), 128'd4);
    chk(tag, bus.o_State, exp);
    consume();
  endtask

  initial begin
    logic [127:0] s1, s2, snap;
    logic         d;
    int           lat;
    n_chk  = 0;
    n_fail = 0;
    build_tables();
    rst_n       = 1'b0;
    bus.i_Valid = 1'b0;
    bus.i_State = '0;
    bus.i_fDec  = 1'b0;
    bus.i_Ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 128'(bus.o_Ready), 128'd1);
    chk("rst_valid", 128'(bus.o_Valid), 128'd0);
    chk("rst_state", bus.o_State, 128'h0);
    rst_n = 1'b1;
    @(negedge clk);

    run_block("fips_enc", 128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0,
              128'hd4bf5d30e0b452aeb84111f11e2798e5);
    run_block("fips_dec", 128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b1,
              128'h193de3bea0f4e22b9ac68d2ae9f84808);
    run_block("zero_enc", 128'h0, 1'b0, {16{8'h63}});
    run_block("zero_dec", 128'h0, 1'b1, {16{8'h52}});

    // Backpressure, then output handshake and new acceptance on one edge.
    s1 = {$urandom, $urandom, $urandom, $urandom};
    s2 = {$urandom, $urandom, $urandom, $urandom};
    send(s1, 1'b0);
    wait_out(lat);
    chk("bp_lat", 128'(lat), 128'd4);
    snap = ref_ssr(s1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", 128'(bus.o_Valid), 128'd1);
      chk("bp_ready", 128'(bus.o_Ready), 128'd0);
      chk("bp_state", bus.o_State, snap);
      @(negedge clk);
    end
    bus.i_Ready = 1'b1;
    bus.i_Valid = 1'b1;
    bus.i_State = s2;
    bus.i_fDec  = 1'b1;
    #1;
    chk("b2b_ready", 128'(bus.o_Ready), 128'd1);
    @(posedge clk);
    @(negedge clk);
    bus.i_Ready = 1'b0;
    bus.i_Valid = 1'b0;
    chk("b2b_valid_drop", 128'(bus.o_Valid), 128'd0);
    wait_out(lat);
    chk("b2b_lat", 128'(lat), 128'd4);
    chk("b2b_state", bus.o_State, ref_ssr(s2, 1'b1));
    consume();

    // Reset two cycles into a block.
    send({$urandom, $urandom, $urandom, $urandom}, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 128'(bus.o_Valid), 128'd0);
    chk("mid_rst_ready", 128'(bus.o_Ready), 128'd1);
    chk("mid_rst_state", bus.o_State, 128'h0);
    repeat (3) @(negedge clk);
    chk("mid_rst_hold_valid", 128'(bus.o_Valid), 128'd0);
    rst_n = 1'b1;
    @(negedge clk);
    s1 = {$urandom, $urandom, $urandom, $urandom};
    run_block("post_rst", s1, 1'b1, ref_ssr(s1, 1'b1));

    // i_Valid held through BUSY with different data must be ignored.
    s1 = {$urandom, $urandom, $urandom, $urandom};
    send(s1, 1'b0);
    bus.i_Valid = 1'b1;
    bus.i_State = ~s1;
    bus.i_fDec  = 1'b1;
    wait_out(lat);
    bus.i_Valid = 1'b0;
    chk("busy_ign_lat", 128'(lat), 128'd4);
    chk("busy_ign_state", bus.o_State, ref_ssr(s1, 1'b0));
    consume();

    for (int k = 0; k < 24; k++) begin
      s1 = {$urandom, $urandom, $urandom, $urandom};
      d  = 1'($urandom);
      run_block("rand", s1, d, ref_ssr(s1, d));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
